// File: rtl/board_input_conditioner.sv
// board_input_conditioner
//   Front end for the board command path. Raw push-buttons and slide switches
//   are brought into the clk domain through two-flop synchronisers. Each button
//   is debounced by its own FSM and counter, and a rising debounced edge
//   produces a one-cycle pulse. A press of button 0 ("send") captures the
//   synchronised switch word as a command, which is held under a valid/ack
//   handshake. A press that arrives while a command is still unconsumed is
//   dropped and recorded in a sticky overrun flag.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   button_raw      async raw buttons (active-high)
//   switch_raw      async raw switches
//   button_level    debounced button levels
//   button_pulse    one-cycle pulse per debounced rising edge
//   switch_stable   synchronised switches (not debounced)
//   cmd_switch      captured switch word
//   cmd_valid       cmd_switch holds an unconsumed command
//   cmd_ack         consumer accepts cmd_switch (qualified by cmd_valid)
//   overrun         sticky: a send press was dropped
//   clear_overrun   clears overrun (a simultaneous drop wins)
module board_input_conditioner #(
    parameter int NUM_BUTTONS     = 3,
    parameter int SW_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] button_raw,
    input  logic [SW_WIDTH-1:0]    switch_raw,
    output logic [NUM_BUTTONS-1:0] button_level,
    output logic [NUM_BUTTONS-1:0] button_pulse,
    output logic [SW_WIDTH-1:0]    switch_stable,
    output logic [SW_WIDTH-1:0]    cmd_switch,
    output logic                   cmd_valid,
    input  logic                   cmd_ack,
    output logic                   overrun,
    input  logic                   clear_overrun
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } db_state_e;

    // The counter holds how many consecutive differing edges have been seen;
    // the edge at which it already holds DEBOUNCE_CYCLES-1 is the committing one.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // Two-flop synchronisers
    // ------------------------------------------------------------------
    logic [NUM_BUTTONS-1:0] btn_sync1_q, btn_sync2_q;
    logic [SW_WIDTH-1:0]    sw_sync1_q, sw_sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_sync1_q <= '0;
            btn_sync2_q <= '0;
            sw_sync1_q  <= '0;
            sw_sync2_q  <= '0;
        end else begin
            btn_sync1_q <= button_raw;
            btn_sync2_q <= btn_sync1_q;
            sw_sync1_q  <= switch_raw;
            sw_sync2_q  <= sw_sync1_q;
        end
    end

    assign switch_stable = sw_sync2_q;

    // ------------------------------------------------------------------
    // Per-button debounce FSM
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_db
        db_state_e            state_q, state_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 pulse_q, pulse_d;
        logic                 level;
        logic                 in_b;

        assign in_b = btn_sync2_q[g];

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            case (state_q)
                STABLE_LO: if (in_b) begin
                    state_d = PEND_HI;
                    cnt_d   = CNT_ONE;
                end
                PEND_HI: begin
                    if (!in_b)                 state_d = STABLE_LO;
                    else if (cnt_q == CNT_LAST) state_d = STABLE_HI;
                    else                       cnt_d   = cnt_q + CNT_ONE;
                end
                STABLE_HI: if (!in_b) begin
                    state_d = PEND_LO;
                    cnt_d   = CNT_ONE;
                end
                PEND_LO: begin
                    if (in_b)                  state_d = STABLE_HI;
                    else if (cnt_q == CNT_LAST) state_d = STABLE_LO;
                    else                       cnt_d   = cnt_q + CNT_ONE;
                end
                default: state_d = STABLE_LO;
            endcase
        end

        // Level is a decode of the state: high while stable-high or while a
        // falling change is still pending confirmation.
        always_comb begin
            level   = (state_q == STABLE_HI) || (state_q == PEND_LO);
            pulse_d = (state_q == PEND_HI) && (state_d == STABLE_HI);
        end

        assign button_level[g] = level;
        assign button_pulse[g] = pulse_q;
    end

    // ------------------------------------------------------------------
    // Command capture on the send button
    // ------------------------------------------------------------------
    logic [SW_WIDTH-1:0] cmd_sw_q, cmd_sw_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                ovr_q, ovr_d;
    logic                send, drop;

    always_comb begin
        send        = button_pulse[0];
        drop        = send && cmd_valid_q && !cmd_ack;
        cmd_sw_d    = cmd_sw_q;
        cmd_valid_d = cmd_valid_q;
        if (send) begin
            // An ack in the same cycle frees the slot, so the new word loads.
            if (!cmd_valid_q || cmd_ack) begin
                cmd_sw_d    = switch_stable;
                cmd_valid_d = 1'b1;
            end
        end else if (cmd_valid_q && cmd_ack) begin
            cmd_valid_d = 1'b0;
        end
        if (drop)               ovr_d = 1'b1;
        else if (clear_overrun) ovr_d = 1'b0;
        else                    ovr_d = ovr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_sw_q    <= '0;
            cmd_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            cmd_sw_q    <= cmd_sw_d;
            cmd_valid_q <= cmd_valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign cmd_switch = cmd_sw_q;
    assign cmd_valid  = cmd_valid_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
module tb_board_input_conditioner;

    localparam int NB = 3;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] button_raw;
    logic [SW-1:0] switch_raw;
    logic [NB-1:0] button_level;
    logic [NB-1:0] button_pulse;
    logic [SW-1:0] switch_stable;
    logic [SW-1:0] cmd_switch;
    logic          cmd_valid;
    logic          cmd_ack;
    logic          overrun;
    logic          clear_overrun;

    board_input_conditioner #(
        .NUM_BUTTONS(NB), .SW_WIDTH(SW), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)
    ) dut (
        .clk(clk), .reset(reset), .button_raw(button_raw), .switch_raw(switch_raw),
        .button_level(button_level), .button_pulse(button_pulse),
        .switch_stable(switch_stable), .cmd_switch(cmd_switch), .cmd_valid(cmd_valid),
        .cmd_ack(cmd_ack), .overrun(overrun), .clear_overrun(clear_overrun)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [SW-1:0] exp_q[$];

    typedef struct {
        logic [SW-1:0] sw;
        bit            ack_p;     // ack during the pulse cycle
        bit            clr_p;     // clear_overrun during the pulse cycle
        bit            ack_a;     // ack after the press
        bit            clr_a;     // clear after the press
        bit            accept;    // press should load a command
        bit            exp_valid;
        logic [SW-1:0] exp_sw;
        bit            exp_ovr;
    } vec_t;

    vec_t tbl[8];

    function automatic vec_t mk(logic [SW-1:0] sw, bit ap, bit cp, bit aa, bit ca,
                                bit acc, bit ev, logic [SW-1:0] es, bit eo);
        vec_t v;
        v.sw = sw; v.ack_p = ap; v.clr_p = cp; v.ack_a = aa; v.clr_a = ca;
        v.accept = acc; v.exp_valid = ev; v.exp_sw = es; v.exp_ovr = eo;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every newly presented command is popped and compared.
    initial begin
        logic          prev_v;
        logic [SW-1:0] prev_s;
        prev_v = 1'b0;
        prev_s = '0;
        forever begin
            @(posedge clk);
            #1;
            if (cmd_valid === 1'b1 && (!prev_v || cmd_switch !== prev_s)) begin
                if (exp_q.size() == 0) chk("sb_unexpected_cmd", {24'd0, cmd_switch}, 32'hFFFF_FFFF);
                else                   chk("sb_cmd", {24'd0, cmd_switch}, {24'd0, exp_q.pop_front()});
            end
            prev_v = cmd_valid;
            prev_s = cmd_switch;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Full button-0 press: rise, optional ack/clear in the pulse cycle, release.
    task automatic press(vec_t v, string name);
        switch_raw    = v.sw;
        button_raw[0] = 1'b1;
        if (v.accept) exp_q.push_back(v.sw);
        step(6);
        chk({name, "_pulse"}, {31'd0, button_pulse[0]}, 32'd1);
        cmd_ack       = v.ack_p;
        clear_overrun = v.clr_p;
        step(1);
        cmd_ack       = 1'b0;
        clear_overrun = 1'b0;
        button_raw[0] = 1'b0;
        step(6);
        chk({name, "_released"}, {31'd0, button_level[0]}, 32'd0);
    endtask

    initial begin
        bit seen;
        int pat[10];
        tbl[0] = mk(8'h11, 0, 0, 0, 0, 1, 1, 8'h11, 0);
        tbl[1] = mk(8'h22, 0, 0, 0, 0, 0, 1, 8'h11, 1);
        tbl[2] = mk(8'h44, 0, 1, 0, 0, 0, 1, 8'h11, 1);
        tbl[3] = mk(8'h55, 0, 0, 0, 1, 0, 1, 8'h11, 0);
        tbl[4] = mk(8'h33, 1, 0, 0, 0, 1, 1, 8'h33, 0);
        tbl[5] = mk(8'h66, 0, 0, 1, 0, 0, 0, 8'h33, 1);
        tbl[6] = mk(8'h77, 1, 1, 0, 0, 1, 1, 8'h77, 0);
        tbl[7] = mk(8'h99, 1, 0, 0, 0, 1, 1, 8'h99, 0);

        reset = 1'b1; button_raw = '0; switch_raw = '0;
        cmd_ack = 1'b0; clear_overrun = 1'b0;
        step(3);
        chk("rst_level", {29'd0, button_level}, 32'd0);
        chk("rst_pulse", {29'd0, button_pulse}, 32'd0);
        chk("rst_cmd", {23'd0, cmd_valid, cmd_switch}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        step(1);

        // Clean press with switch word A5, button held afterwards.
        switch_raw = 8'hA5; button_raw[0] = 1'b1;
        exp_q.push_back(8'hA5);
        step(3);
        chk("sw_sync", {24'd0, switch_stable}, 32'hA5);
        step(2);
        chk("t1_level_early", {31'd0, button_level[0]}, 32'd0);
        step(1);
        chk("t1_level", {31'd0, button_level[0]}, 32'd1);
        chk("t1_pulse", {31'd0, button_pulse[0]}, 32'd1);
        step(1);
        chk("t1_pulse_low", {31'd0, button_pulse[0]}, 32'd0);
        chk("t1_valid", {31'd0, cmd_valid}, 32'd1);
        chk("t1_cmd", {24'd0, cmd_switch}, 32'hA5);

        // Short glitch on button 1 must be rejected.
        seen = 1'b0;
        button_raw[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin step(1); seen |= button_level[1] | button_pulse[1]; end
        button_raw[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin step(1); seen |= button_level[1] | button_pulse[1]; end
        chk("btn1_glitch", {31'd0, seen}, 32'd0);

        // Release bounce on button 0.
        pat = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            button_raw[0] = pat[i][0];
            step(1);
            seen |= button_pulse[0];
        end
        step(3);
        seen |= button_pulse[0];
        chk("bounce_level_held", {31'd0, button_level[0]}, 32'd1);
        step(1);
        seen |= button_pulse[0];
        chk("bounce_level_fall", {31'd0, button_level[0]}, 32'd0);
        step(2);
        seen |= button_pulse[0];
        chk("bounce_no_pulse", {31'd0, seen}, 32'd0);

        // Ack consumes; a second ack with nothing valid is ignored.
        cmd_ack = 1'b1; step(1); cmd_ack = 1'b0;
        chk("ack_valid", {31'd0, cmd_valid}, 32'd0);
        chk("ack_hold_sw", {24'd0, cmd_switch}, 32'hA5);
        cmd_ack = 1'b1; step(1); cmd_ack = 1'b0;
        chk("ack_idle", {30'd0, cmd_valid, overrun}, 32'd0);

        // Table of send presses.
        for (int k = 0; k < 8; k++) begin
            press(tbl[k], $sformatf("vec%0d", k));
            if (tbl[k].ack_a) begin cmd_ack = 1'b1; step(1); cmd_ack = 1'b0; end
            if (tbl[k].clr_a) begin clear_overrun = 1'b1; step(1); clear_overrun = 1'b0; end
            step(1);
            chk($sformatf("vec%0d_valid", k), {31'd0, cmd_valid}, {31'd0, tbl[k].exp_valid});
            chk($sformatf("vec%0d_sw", k), {24'd0, cmd_switch}, {24'd0, tbl[k].exp_sw});
            chk($sformatf("vec%0d_ovr", k), {31'd0, overrun}, {31'd0, tbl[k].exp_ovr});
        end

        // Reset two cycles into a pending press, button held throughout.
        switch_raw = 8'hC3; button_raw[0] = 1'b1;
        exp_q.push_back(8'hC3);
        step(4);
        reset = 1'b1;
        step(2);
        chk("mid_rst_level", {29'd0, button_level}, 32'd0);
        chk("mid_rst_pulse", {29'd0, button_pulse}, 32'd0);
        chk("mid_rst_sw", {24'd0, switch_stable}, 32'd0);
        chk("mid_rst_cmd", {22'd0, overrun, cmd_valid, cmd_switch}, 32'd0);
        reset = 1'b0;
        step(5);
        chk("post_rst_early", {31'd0, button_level[0]}, 32'd0);
        step(1);
        chk("post_rst_level", {31'd0, button_level[0]}, 32'd1);
        chk("post_rst_pulse", {31'd0, button_pulse[0]}, 32'd1);
        step(1);
        chk("post_rst_valid", {31'd0, cmd_valid}, 32'd1);
        chk("post_rst_cmd", {24'd0, cmd_switch}, 32'hC3);
        step(2);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
